// File: rtl/psola_playback_if.sv
// Signal bundle between the PSOLA playback block, its output BRAM ports and the audio path.
// The master side is the playback block; the slave side is the BRAM/audio environment.
interface psola_playback_if #(
  parameter int WINDOW_SIZE = 2048,
  parameter int OUT_WIDTH   = 16
);
  localparam int AW = $clog2(WINDOW_SIZE) + 1;

  logic                 window_len_valid_in;
  logic [11:0]          window_len_in;
  logic                 sample_tick_in;
  logic [AW-1:0]        read_addr;
  logic [31:0]          read_val_in;
  logic [AW-1:0]        clear_addr;
  logic                 clear_valid_out;
  logic [OUT_WIDTH-1:0] sample_out;
  logic                 sample_valid_out;
  logic                 busy_out;
  logic                 done_out;
  logic                 underrun_out;
  logic                 overrun_out;

  modport master (
    input  window_len_valid_in, window_len_in, sample_tick_in, read_val_in,
    output read_addr, clear_addr, clear_valid_out, sample_out, sample_valid_out,
           busy_out, done_out, underrun_out, overrun_out
  );

  modport slave (
    output window_len_valid_in, window_len_in, sample_tick_in, read_val_in,
    input  read_addr, clear_addr, clear_valid_out, sample_out, sample_valid_out,
           busy_out, done_out, underrun_out, overrun_out
  );
endinterface

// File: rtl/psola_playback.sv
// Drains the PSOLA overlap-add buffer one sample per audio tick, saturating Q.FRAC_BITS
// accumulators to signed PCM and clearing each location after it has been read.
//
// state | meaning
// IDLE  | no window; ticks produce a zero sample and an underrun pulse
// FETCH | reading buffer[pos], waiting out the 2-cycle BRAM latency
// READY | converted sample held, waiting for the next tick
module psola_playback #(
  parameter int WINDOW_SIZE     = 2048,
  parameter int FRAC_BITS       = 10,
  parameter int OUT_WIDTH       = 16,
  parameter int LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  psola_playback_if.master pb
);
  localparam int          AW      = LOG_WINDOW_SIZE + 1;
  localparam logic [11:0] LEN_MAX = 12'(WINDOW_SIZE);
  localparam int          SAT_MAX = (2 ** (OUT_WIDTH - 1)) - 1;
  localparam int          SAT_MIN = -(2 ** (OUT_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

  state_t               state, state_nx;
  logic [AW-1:0]        pos, pos_nx, len, len_nx, pend_len, pend_len_nx;
  logic [AW-1:0]        pos_inc, len_clamped, clear_addr_q, clear_addr_nx;
  logic                 pend_valid, pend_valid_nx, len_ok;
  logic [OUT_WIDTH-1:0] hold, hold_nx, sample_q, sample_nx, conv;
  logic [1:0]           fetch_cnt, fetch_cnt_nx;
  logic                 sample_valid_q, sample_valid_nx, clear_valid_q, clear_valid_nx;
  logic                 busy_q, busy_nx, done_q, done_nx;
  logic                 underrun_q, underrun_nx, overrun_q, overrun_nx;
  logic signed [31:0]   shifted;

  assign len_ok      = pb.window_len_valid_in && (pb.window_len_in != 12'd0);
  assign len_clamped = (pb.window_len_in > LEN_MAX) ? AW'(WINDOW_SIZE) : AW'(pb.window_len_in);
  assign pos_inc     = pos + AW'(1);
  assign shifted     = $signed(pb.read_val_in) >>> FRAC_BITS;

  always_comb begin
    if (shifted > SAT_MAX)      conv = OUT_WIDTH'(SAT_MAX);
    else if (shifted < SAT_MIN) conv = OUT_WIDTH'(SAT_MIN);
    else                        conv = OUT_WIDTH'(shifted);
  end

  always_comb begin
    state_nx        = state;
    pos_nx          = pos;
    len_nx          = len;
    pend_len_nx     = pend_len;
    pend_valid_nx   = pend_valid;
    hold_nx         = hold;
    fetch_cnt_nx    = fetch_cnt;
    sample_nx       = sample_q;
    sample_valid_nx = 1'b0;
    clear_addr_nx   = clear_addr_q;
    clear_valid_nx  = 1'b0;
    done_nx         = 1'b0;
    underrun_nx     = 1'b0;
    overrun_nx      = 1'b0;

    if (len_ok) begin
      if (state == IDLE) begin
        len_nx       = len_clamped;
        pos_nx       = '0;
        fetch_cnt_nx = '0;
        state_nx     = FETCH;
      end else begin
        overrun_nx    = pend_valid;
        pend_len_nx   = len_clamped;
        pend_valid_nx = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (pb.sample_tick_in) begin
          sample_nx       = '0;
          sample_valid_nx = 1'b1;
          underrun_nx     = 1'b1;
        end
      end
      FETCH: begin
        if (pb.sample_tick_in) begin
          sample_nx       = '0;
          sample_valid_nx = 1'b1;
          underrun_nx     = 1'b1;
        end
        fetch_cnt_nx = fetch_cnt + 2'd1;
        if (fetch_cnt == 2'd2) begin
          hold_nx      = conv;
          fetch_cnt_nx = '0;
          state_nx     = READY;
        end
      end
      READY: begin
        if (pb.sample_tick_in) begin
          sample_nx       = hold;
          sample_valid_nx = 1'b1;
          clear_addr_nx   = pos;
          clear_valid_nx  = 1'b1;
          fetch_cnt_nx    = '0;
          if (pos_inc < len) begin
            pos_nx   = pos_inc;
            state_nx = FETCH;
          end else begin
            done_nx = 1'b1;
            pos_nx  = '0;
            // a length arriving with the final tick has already landed in the pending slot
            if (pend_valid_nx) begin
              len_nx        = pend_len_nx;
              pend_valid_nx = 1'b0;
              state_nx      = FETCH;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pos            <= '0;
      len            <= '0;
      pend_len       <= '0;
      pend_valid     <= 1'b0;
      hold           <= '0;
      fetch_cnt      <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      clear_addr_q   <= '0;
      clear_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state          <= state_nx;
      pos            <= pos_nx;
      len            <= len_nx;
      pend_len       <= pend_len_nx;
      pend_valid     <= pend_valid_nx;
      hold           <= hold_nx;
      fetch_cnt      <= fetch_cnt_nx;
      sample_q       <= sample_nx;
      sample_valid_q <= sample_valid_nx;
      clear_addr_q   <= clear_addr_nx;
      clear_valid_q  <= clear_valid_nx;
      busy_q         <= busy_nx;
      done_q         <= done_nx;
      underrun_q     <= underrun_nx;
      overrun_q      <= overrun_nx;
    end
  end

  assign pb.read_addr        = pos;
  assign pb.clear_addr       = clear_addr_q;
  assign pb.clear_valid_out  = clear_valid_q;
  assign pb.sample_out       = sample_q;
  assign pb.sample_valid_out = sample_valid_q;
  assign pb.busy_out         = busy_q;
  assign pb.done_out         = done_q;
  assign pb.underrun_out     = underrun_q;
  assign pb.overrun_out      = overrun_q;
endmodule
